// File: rtl/ksa_bist_ctrl_if.sv
// ksa_bist_ctrl_if: adder drive/sample bus plus start/status of the KSA BIST engine
interface ksa_bist_ctrl_if;
  logic        start;
  logic [15:0] a_o;
  logic [15:0] b_o;
  logic        c_in_o;
  logic [15:0] sum_i;
  logic        c_out_i;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [15:0] first_fail_idx;
  modport master (
    input  start, sum_i, c_out_i,
    output a_o, b_o, c_in_o, busy, done, pass, err_count, first_fail_idx
  );
  modport slave (
    output start, sum_i, c_out_i,
    input  a_o, b_o, c_in_o, busy, done, pass, err_count, first_fail_idx
  );
endinterface

// File: rtl/ksa_bist_ctrl.sv
// ksa_bist_ctrl: BIST engine driving directed then LFSR vectors into a 16-bit adder and checking results
module ksa_bist_ctrl #(
  parameter int unsigned NUM_VECTORS   = 16,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] SEED_A        = 16'hACE1,
  parameter logic [15:0] SEED_B        = 16'h1D0F
) (
  input logic             clk,
  input logic             rst_n,
  ksa_bist_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
  localparam logic [15:0] L_SEED_A = (SEED_A == 16'h0) ? 16'hACE1 : SEED_A;
  localparam logic [15:0] L_SEED_B = (SEED_B == 16'h0) ? 16'hACE1 : SEED_B;
  localparam logic [15:0] L_LAST   = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] L_SETTLE = 16'(SETTLE_CYCLES - 1);
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0);
  endfunction
  // vectors 0-2 are carry-chain corner cases; the rest come straight from the LFSRs
  function automatic logic [32:0] vec_of(input logic [15:0] i, input logic [15:0] la, input logic [15:0] lb);
    return (i == 16'd0) ? {16'hFFFF, 16'h0001, 1'b0} :
           (i == 16'd1) ? {16'hFFFF, 16'hFFFF, 1'b1} :
           (i == 16'd2) ? {16'hA701, 16'h9500, 1'b0} :
                          {la, lb, la[0] ^ lb[0]};
  endfunction
  state_t      r_state, w_next;
  logic [15:0] r_a, r_b, r_la, r_lb, r_idx, r_cnt, r_err, r_ffi;
  logic        r_cin;
  logic        w_start, w_settled, w_last, w_mis;
  logic [15:0] w_nidx, w_la_n, w_lb_n;
  logic [32:0] w_vec_n, w_vec0;
  logic [16:0] w_exp;
  assign w_start   = ((r_state == IDLE) || (r_state == DONE)) && bus.start;
  assign w_settled = r_cnt == L_SETTLE;
  assign w_last    = r_idx == L_LAST;
  assign w_nidx    = r_idx + 16'd1;
  // LFSRs step only on the way to vector 4+, so vector 3 sees the raw seeds
  assign w_la_n    = (w_nidx > 16'd3) ? lfsr_step(r_la) : r_la;
  assign w_lb_n    = (w_nidx > 16'd3) ? lfsr_step(r_lb) : r_lb;
  assign w_vec_n   = vec_of(w_nidx, w_la_n, w_lb_n);
  assign w_vec0    = vec_of(16'd0, L_SEED_A, L_SEED_B);
  assign w_exp     = {1'b0, r_a} + {1'b0, r_b} + {16'h0, r_cin};
  assign w_mis     = w_exp != {bus.c_out_i, bus.sum_i};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: w_next = bus.start ? APPLY : r_state;
      APPLY:      w_next = w_settled ? CHECK : APPLY;
      CHECK:      w_next = w_last ? DONE : APPLY;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
      r_la  <= L_SEED_A;
      r_lb  <= L_SEED_B;
      r_idx <= '0;
      r_cnt <= '0;
      r_err <= '0;
      r_ffi <= 16'hFFFF;
    end else begin
      r_cnt <= ((r_state == APPLY) && !w_settled) ? r_cnt + 16'd1 : 16'd0;
      if (w_start) begin
        r_idx               <= '0;
        r_err               <= '0;
        r_ffi               <= 16'hFFFF;
        r_la                <= L_SEED_A;
        r_lb                <= L_SEED_B;
        {r_a, r_b, r_cin}   <= w_vec0;
      end else if (r_state == CHECK) begin
        if (w_mis && (r_err != 16'hFFFF)) r_err <= r_err + 16'd1;
        if (w_mis && (r_err == 16'h0))    r_ffi <= r_idx;
        if (!w_last) begin
          r_idx             <= w_nidx;
          r_la              <= w_la_n;
          r_lb              <= w_lb_n;
          {r_a, r_b, r_cin} <= w_vec_n;
        end
      end
    end
  assign bus.a_o            = r_a;
  assign bus.b_o            = r_b;
  assign bus.c_in_o         = r_cin;
  assign bus.busy           = (r_state == APPLY) || (r_state == CHECK);
  assign bus.done           = r_state == DONE;
  assign bus.pass           = (r_state == DONE) && (r_err == 16'h0);
  assign bus.err_count      = r_err;
  assign bus.first_fail_idx = r_ffi;
endmodule

// File: tb/tb_ksa_bist_ctrl.sv
// tb_ksa_bist_ctrl: randomized self-checking bench for ksa_bist_ctrl against a vector-list reference model
module tb_ksa_bist_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int mode = 0;
  logic [15:0] mask = 16'h0;
  int sel = 0;
  ksa_bist_ctrl_if b1();
  ksa_bist_ctrl_if b2();
  ksa_bist_ctrl #(.NUM_VECTORS(8), .SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  ksa_bist_ctrl #(.NUM_VECTORS(6), .SETTLE_CYCLES(2), .SEED_A(16'h0), .SEED_B(16'h1234)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  // adder model with optional faults: 1 carry-out stuck 0, 2 sum[15] stuck 0, 3 sum xor mask when a is odd
  function automatic logic [16:0] fault_adder(input logic [15:0] a, input logic [15:0] b, input logic c, input int m, input logic [15:0] mk);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b} + {16'h0, c};
    if (m == 1) s[16] = 1'b0;
    if (m == 2) s[15] = 1'b0;
    if (m == 3 && a[0]) s[15:0] = s[15:0] ^ mk;
    return s;
  endfunction
  always_comb {b1.c_out_i, b1.sum_i} = fault_adder(b1.a_o, b1.b_o, b1.c_in_o, mode, mask);
  always_comb {b2.c_out_i, b2.sum_i} = fault_adder(b2.a_o, b2.b_o, b2.c_in_o, 0, 16'h0);
  logic [15:0] oa, ob, oerr, offi;
  logic        oc, obusy, odone, opass;
  assign oa    = sel != 0 ? b2.a_o : b1.a_o;
  assign ob    = sel != 0 ? b2.b_o : b1.b_o;
  assign oc    = sel != 0 ? b2.c_in_o : b1.c_in_o;
  assign obusy = sel != 0 ? b2.busy : b1.busy;
  assign odone = sel != 0 ? b2.done : b1.done;
  assign opass = sel != 0 ? b2.pass : b1.pass;
  assign oerr  = sel != 0 ? b2.err_count : b1.err_count;
  assign offi  = sel != 0 ? b2.first_fail_idx : b1.first_fail_idx;
  int ma[$], mb[$], mc[$];
  int exp_err, exp_ffi;
  function automatic int lstep(input int l);
    return (l >> 1) ^ (((l % 2) == 1) ? 'hB400 : 0);
  endfunction
  task automatic build_model(input int n, input int sa, input int sb, input int m, input logic [15:0] mk);
    int la, lb, a, b, c, want;
    logic [16:0] got;
    ma.delete(); mb.delete(); mc.delete();
    la = (sa == 0) ? 'hACE1 : sa;
    lb = (sb == 0) ? 'hACE1 : sb;
    exp_err = 0;
    exp_ffi = 'hFFFF;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin a = 'hFFFF; b = 1; c = 0; end
      else if (i == 1) begin a = 'hFFFF; b = 'hFFFF; c = 1; end
      else if (i == 2) begin a = 'hA701; b = 'h9500; c = 0; end
      else begin
        if (i >= 4) begin la = lstep(la); lb = lstep(lb); end
        a = la; b = lb; c = (la ^ lb) % 2;
      end
      ma.push_back(a); mb.push_back(b); mc.push_back(c);
      want = a + b + c;
      got = fault_adder(16'(a), 16'(b), c[0], m, mk);
      if (int'(got) != want) begin
        if (exp_err < 'hFFFF) exp_err++;
        if (exp_ffi == 'hFFFF) exp_ffi = i;
      end
    end
  endtask
  task automatic check_reset(input string tag);
    checks++;
    if ({oa, ob, oc} !== 33'h0) begin failures++; $display("FAIL %s vec got %h/%h/%b want 0", tag, oa, ob, oc); end
    checks++;
    if ({obusy, odone, opass} !== 3'b000) begin failures++; $display("FAIL %s flags got busy=%b done=%b pass=%b want 000", tag, obusy, odone, opass); end
    checks++;
    if (oerr !== 16'h0) begin failures++; $display("FAIL %s err_count got %h want 0", tag, oerr); end
    checks++;
    if (offi !== 16'hFFFF) begin failures++; $display("FAIL %s first_fail_idx got %h want FFFF", tag, offi); end
  endtask
  task automatic pulse_start(input int s);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    @(negedge clk);
    if (s != 0) b2.start = 1'b1; else b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    b2.start = 1'b0;
  endtask
  // called at the first falling edge after the edge that accepted start
  task automatic check_run(input int n, input int s, input string tag);
    int i;
    for (int k = 0; k < n * (s + 1); k++) begin
      i = k / (s + 1);
      checks++;
      if (obusy !== 1'b1 || odone !== 1'b0) begin failures++; $display("FAIL %s busy@%0d got busy=%b done=%b want 1/0", tag, k, obusy, odone); end
      checks++;
      if ({oa, ob, oc} !== {ma[i][15:0], mb[i][15:0], mc[i][0]}) begin
        failures++;
        $display("FAIL %s vec%0d got %h/%h/%b want %h/%h/%b", tag, i, oa, ob, oc, ma[i][15:0], mb[i][15:0], mc[i][0]);
      end
      @(negedge clk);
    end
    checks++;
    if (obusy !== 1'b0 || odone !== 1'b1) begin failures++; $display("FAIL %s end got busy=%b done=%b want 0/1", tag, obusy, odone); end
    checks++;
    if (opass !== (exp_err == 0)) begin failures++; $display("FAIL %s pass got %b want %b", tag, opass, exp_err == 0); end
    checks++;
    if (oerr !== 16'(exp_err)) begin failures++; $display("FAIL %s err_count got %0d want %0d", tag, oerr, exp_err); end
    checks++;
    if (offi !== 16'(exp_ffi)) begin failures++; $display("FAIL %s first_fail_idx got %h want %h", tag, offi, 16'(exp_ffi)); end
  endtask
  task automatic test_reset();
    b1.start = 1'b0;
    b2.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    sel = 0; #1 check_reset("reset_dut1");
    sel = 1; #1 check_reset("reset_dut2");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    sel = 0; #1 check_reset("idle_dut1");
    sel = 1; #1 check_reset("idle_dut2");
  endtask
  task automatic test_good_adder();
    sel = 0; mode = 0;
    build_model(8, 'hACE1, 'h1D0F, 0, 16'h0);
    pulse_start(0);
    check_run(8, 1, "good");
  endtask
  task automatic test_faults();
    sel = 0; mode = 1;
    build_model(8, 'hACE1, 'h1D0F, 1, 16'h0);
    pulse_start(0);
    check_run(8, 1, "cout0");
    mode = 2;
    build_model(8, 'hACE1, 'h1D0F, 2, 16'h0);
    pulse_start(0);
    check_run(8, 1, "sum15");
    for (int r = 0; r < 4; r++) begin
      mode = 3;
      mask = 16'($urandom_range(1, 'hFFFF));
      build_model(8, 'hACE1, 'h1D0F, 3, mask);
      pulse_start(0);
      check_run(8, 1, "randflip");
    end
  endtask
  task automatic test_mid_reset();
    sel = 0; mode = 0;
    build_model(8, 'hACE1, 'h1D0F, 0, 16'h0);
    pulse_start(0);
    repeat (10) @(negedge clk);
    checks++;
    if (oa !== ma[5][15:0]) begin failures++; $display("FAIL midrst_vec5 got %h want %h", oa, ma[5][15:0]); end
    #2 rst_n = 1'b0;
    #1 check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(0);
    check_run(8, 1, "after_rst");
  endtask
  task automatic test_back_to_back();
    sel = 0; mode = 3;
    mask = 16'($urandom_range(1, 'hFFFF));
    build_model(8, 'hACE1, 'h1D0F, 3, mask);
    pulse_start(0);
    check_run(8, 1, "b2b_first");
    mode = 0;
    build_model(8, 'hACE1, 'h1D0F, 0, 16'h0);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    check_run(8, 1, "b2b_second");
  endtask
  task automatic test_seed0_restart();
    sel = 1;
    build_model(6, 0, 'h1234, 0, 16'h0);
    checks++;
    if (ma[3] != 'hACE1) begin failures++; $display("FAIL seed0_model got %h want ACE1", ma[3]); end
    pulse_start(1);
    check_run(6, 2, "seed0");
    b2.start = 1'b1;
    @(negedge clk);
    checks++;
    if (odone !== 1'b0 || obusy !== 1'b1) begin failures++; $display("FAIL restart got done=%b busy=%b want 0/1", odone, obusy); end
    b2.start = 1'b0;
    check_run(6, 2, "restart");
  endtask
  initial begin
    test_reset();
    test_good_adder();
    test_faults();
    test_mid_reset();
    test_back_to_back();
    test_seed0_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
